// File: rtl/instruction_cache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package instruction_cache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMiss,
    StFill
  } icache_state_e;

  localparam logic [31:0] Nop            = 32'h0000_0013;
  localparam int unsigned BlockWidth     = 128;
  localparam int unsigned BlockAddrWidth = 28;

endpackage

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with a single-block refill from instruction memory.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      READ,
  input  logic [31:0]               ADDRESS,
  output logic [31:0]               INSTRUCTION,
  output logic                      BUSYWAIT,
  output logic                      MEM_READ,
  output logic [BlockAddrWidth-1:0] MEM_BLOCK_ADDRESS,
  input  logic [BlockWidth-1:0]     MEM_READINST,
  input  logic                      MEM_BUSYWAIT
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]               HIT_COUNT,
  output logic [31:0]               MISS_COUNT
`endif
);

  localparam int unsigned IndexBits = $clog2(NUM_LINES);
  localparam int unsigned TagBits   = BlockAddrWidth - IndexBits;

  icache_state_e state_q, state_d;

  logic [BlockAddrWidth-1:0] miss_addr_q, miss_addr_d;
  logic                      req_seen_q, req_seen_d;
  logic [NUM_LINES-1:0]      valid_q;
  logic [TagBits-1:0]        tag_q  [NUM_LINES];
  logic [BlockWidth-1:0]     data_q [NUM_LINES];

  logic [IndexBits-1:0] idx;
  logic [TagBits-1:0]   req_tag;
  logic [IndexBits-1:0] fill_idx;
  logic [TagBits-1:0]   fill_tag;
  logic [6:0]           word_off;
  logic                 hit;
  logic                 line_load;
  logic [1:0]           unused_byte_sel;

  assign idx             = ADDRESS[4 +: IndexBits];
  assign req_tag         = ADDRESS[31 -: TagBits];
  assign word_off        = {ADDRESS[3:2], 5'b0};
  assign fill_idx        = miss_addr_q[IndexBits-1:0];
  assign fill_tag        = miss_addr_q[BlockAddrWidth-1 -: TagBits];
  assign unused_byte_sel = ADDRESS[1:0];

  assign hit = READ && valid_q[idx] && (tag_q[idx] == req_tag) && (state_q == StIdle);

  // Memory data is valid in the cycle busywait falls, so the line is captured on MISS exit.
  assign line_load = (state_q == StMiss) && req_seen_q && !MEM_BUSYWAIT;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    req_seen_d  = req_seen_q;
    case (state_q)
      StIdle: begin
        if (READ && !hit) begin
          state_d     = StMiss;
          miss_addr_d = ADDRESS[31:4];
          req_seen_d  = 1'b0;
        end
      end
      StMiss: begin
        if (MEM_BUSYWAIT) begin
          req_seen_d = 1'b1;
        end
        if (req_seen_q && !MEM_BUSYWAIT) begin
          state_d = StFill;
        end
      end
      StFill:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    INSTRUCTION = Nop;
    if (hit) begin
      INSTRUCTION = data_q[idx][word_off +: 32];
    end
    BUSYWAIT = (READ && !hit) || (state_q != StIdle);
    MEM_READ = (state_q == StMiss);
  end

  assign MEM_BLOCK_ADDRESS = miss_addr_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      miss_addr_q <= '0;
      req_seen_q  <= 1'b0;
      valid_q     <= '0;
    end else begin
      miss_addr_q <= miss_addr_d;
      req_seen_q  <= req_seen_d;
      if (state_q == StFill) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Payload needs no reset: a line is only visible once its valid bit is set in FILL.
  always_ff @(posedge CLOCK) begin
    if (line_load) begin
      data_q[fill_idx] <= MEM_READINST;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if ((state_q == StIdle) && (state_d == StMiss)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_count_q;
  assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios plus random fetches against a
// block-residency model and a behavioural block-read memory. Define ICACHE_PERF_EN for counters.
module tb_instruction_cache;

  localparam logic [31:0] NopWord = 32'h0000_0013;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic         READ;
  logic [31:0]  ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_BLOCK_ADDRESS;
  logic [127:0] MEM_READINST;
  logic         MEM_BUSYWAIT;
`ifdef ICACHE_PERF_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  instruction_cache dut (
    .CLOCK            (CLOCK),
    .RESET            (RESET),
    .READ             (READ),
    .ADDRESS          (ADDRESS),
    .INSTRUCTION      (INSTRUCTION),
    .BUSYWAIT         (BUSYWAIT),
    .MEM_READ         (MEM_READ),
    .MEM_BLOCK_ADDRESS(MEM_BLOCK_ADDRESS),
    .MEM_READINST     (MEM_READINST),
    .MEM_BUSYWAIT     (MEM_BUSYWAIT)
`ifdef ICACHE_PERF_EN
    ,
    .HIT_COUNT        (hit_count),
    .MISS_COUNT       (miss_count)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int exp_hits   = 0;
  int exp_misses = 0;

  // Instruction memory contents: a small array, plus a hashed pattern for high addresses.
  logic [31:0] mem_arr [256];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:10] == 22'd0) return mem_arr[a[9:2]];
    return {a[31:2], 2'b00} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] blk);
    logic [127:0] b;
    for (int w = 0; w < 4; w++) b[32*w +: 32] = mem_word({blk, w[1:0], 2'b00});
    return b;
  endfunction

  // Block-read memory: busy for a random 1..4 cycles, then data held until READ drops.
  int          mem_ph;
  int          mem_cnt;
  int          cur_lat;
  int          lat_next;
  logic [27:0] mem_blk;

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      mem_ph       <= 0;
      mem_cnt      <= 0;
      MEM_BUSYWAIT <= 1'b0;
    end else begin
      case (mem_ph)
        0: if (MEM_READ) begin
          lat_next = int'($urandom_range(1, 4));
          cur_lat      <= lat_next;
          mem_cnt      <= lat_next;
          mem_blk      <= MEM_BLOCK_ADDRESS;
          MEM_BUSYWAIT <= 1'b1;
          mem_ph       <= 1;
        end
        1: if (mem_cnt == 1) begin
          MEM_BUSYWAIT <= 1'b0;
          MEM_READINST <= mem_block(mem_blk);
          mem_ph       <= 2;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
        default: if (!MEM_READ) mem_ph <= 0;
      endcase
    end
  end

  // Reference model: which block address each line holds, if any.
  logic [27:0] line_blk [8];
  bit          line_ok  [8];

  function automatic bit model_hit(input logic [31:0] a);
    logic [27:0] blk = a[31:4];
    int          ln  = int'(blk % 28'd8);
    return line_ok[ln] && (line_blk[ln] == blk);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    logic [27:0] blk = a[31:4];
    int          ln  = int'(blk % 28'd8);
    line_ok[ln]  = 1'b1;
    line_blk[ln] = blk;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) line_ok[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One fetch; returns at the negedge where the word is delivered.
  task automatic fetch(input logic [31:0] addr);
    int stall;
    @(posedge CLOCK); #1;
    READ    = 1'b1;
    ADDRESS = addr;
    @(negedge CLOCK);
    if (model_hit(addr)) begin
      check1("hit_busy", BUSYWAIT, 1'b0);
      check1("hit_memread", MEM_READ, 1'b0);
      check("hit_word", INSTRUCTION, mem_word(addr));
    end else begin
      check1("miss_busy", BUSYWAIT, 1'b1);
      check("miss_nop", INSTRUCTION, NopWord);
      @(negedge CLOCK);
      check1("miss_memread", MEM_READ, 1'b1);
      check("miss_blkaddr", 32'(MEM_BLOCK_ADDRESS), 32'(addr[31:4]));
      stall = 2;
      while (BUSYWAIT && stall < 60) begin
        @(negedge CLOCK);
        stall++;
      end
      check("miss_penalty", 32'(stall), 32'(cur_lat + 5));
      check("fill_word", INSTRUCTION, mem_word(addr));
      model_fill(addr);
      exp_misses++;
    end
    exp_hits++;
  endtask

  task automatic idle_cycle();
    @(posedge CLOCK); #1;
    READ    = 1'b0;
    ADDRESS = $urandom;
    @(negedge CLOCK);
    check1("idle_busy", BUSYWAIT, 1'b0);
    check1("idle_memread", MEM_READ, 1'b0);
    check("idle_nop", INSTRUCTION, NopWord);
  endtask

  task automatic check_perf(input string tag);
    @(posedge CLOCK); #1;
    READ = 1'b0;
`ifdef ICACHE_PERF_EN
    check({tag, "_hits"}, hit_count, 32'(exp_hits));
    check({tag, "_misses"}, miss_count, 32'(exp_misses));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    logic [31:0] a;
    logic [24:0] t;

    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    mem_arr[0] = 32'h8F10_8093;
    mem_arr[3] = 32'h0000_F613;

    READ    = 1'b0;
    ADDRESS = '0;
    RESET   = 1'b0;
    model_reset();
    #1 RESET = 1'b1;
    repeat (2) @(negedge CLOCK);
    check1("rst_busy", BUSYWAIT, 1'b0);
    check1("rst_memread", MEM_READ, 1'b0);
    check("rst_blkaddr", 32'(MEM_BLOCK_ADDRESS), 32'h0);
    check("rst_nop", INSTRUCTION, NopWord);
    READ = 1'b1;
    #1;
    check1("rst_busy_read", BUSYWAIT, 1'b1);
    READ = 1'b0;
    @(posedge CLOCK); #1;
    RESET = 1'b0;

    // Cold miss on PC 0, then a same-line hit on PC 0xC.
    fetch(32'h0);
    check("s1_word", INSTRUCTION, 32'h8F10_8093);
    fetch(32'hC);
    check("s2_word", INSTRUCTION, 32'h0000_F613);
    check_perf("s2");

    // Conflict on index 0.
    fetch(32'h80);
    fetch(32'h0);

    // PC moves while the miss is outstanding: request stays on the latched block.
    @(posedge CLOCK); #1;
    READ    = 1'b1;
    ADDRESS = 32'h10;
    @(negedge CLOCK);
    check1("s4_miss", BUSYWAIT, 1'b1);
    exp_misses++;
    @(posedge CLOCK); #1;
    ADDRESS = 32'h20;
    cyc = 0;
    @(negedge CLOCK);
    while (MEM_READ && cyc < 60) begin
      check("s4_hold", 32'(MEM_BLOCK_ADDRESS), 32'h1);
      @(negedge CLOCK);
      cyc++;
    end
    check1("s4_fill_busy", BUSYWAIT, 1'b1);
    check1("s4_fill_memread", MEM_READ, 1'b0);
    model_fill(32'h10);
    @(negedge CLOCK);
    check1("s4_remiss_busy", BUSYWAIT, 1'b1);
    check("s4_remiss_nop", INSTRUCTION, NopWord);
    exp_misses++;
    @(negedge CLOCK);
    check1("s4_req2", MEM_READ, 1'b1);
    check("s4_blk2", 32'(MEM_BLOCK_ADDRESS), 32'h2);
    cyc = 0;
    while (BUSYWAIT && cyc < 60) begin
      @(negedge CLOCK);
      cyc++;
    end
    check("s4_word2", INSTRUCTION, mem_word(32'h20));
    model_fill(32'h20);
    exp_hits++;
    fetch(32'h14);

    // Reset in the middle of a miss.
    @(posedge CLOCK); #1;
    READ    = 1'b1;
    ADDRESS = 32'h60;
    @(negedge CLOCK);
    check1("s5_miss", BUSYWAIT, 1'b1);
    @(negedge CLOCK);
    check1("s5_req", MEM_READ, 1'b1);
    #1 RESET = 1'b1;
    #1;
    check1("s5_memread_async", MEM_READ, 1'b0);
    check("s5_blkaddr", 32'(MEM_BLOCK_ADDRESS), 32'h0);
    check1("s5_busy", BUSYWAIT, 1'b1);
    check("s5_nop", INSTRUCTION, NopWord);
    READ = 1'b0;
    #1 RESET = 1'b0;
    model_reset();
    fetch(32'h60);
    fetch(32'h0);

    // Random fetches over a few tags per index, occasionally a far-away PC.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_cycle();
      end else begin
        t = ($urandom_range(0, 7) == 0) ? 25'($urandom) : 25'($urandom_range(0, 3));
        a = {t, 3'($urandom), 2'($urandom), 2'b00};
        fetch(a);
      end
    end
    check_perf("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
